sar_adc4: RTL and testbench
===========================

# sar_adc4

Successive-approximation ADC controller: the measurement-side counterpart of the 4-bit resistor-ladder DAC (`dac4x1`). It drives trial codes into the ladder DAC and reads an external analog comparator (`cmp = vin >= vdac`). It resolves one bit per settle window, MSB first, and returns the converted code with a start/busy/done handshake. Sits between the analog front end (ladder DAC plus comparator) and digital consumers.

## Interface
- `WIDTH`, 4: resolution in bits; trial-code and result width.
- `SETTLE_CYCLES`, 2: clocks the DAC/comparator settle per bit, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: conversion request; sampled only in IDLE.
- `cmp` in 1: comparator output, 1 when vin ≥ DAC voltage.
- `dac_code` out WIDTH: trial code to the ladder DAC select.
- `busy` out 1: high while converting.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out WIDTH: last converted code, held until the next done.

## Operation
- Reset values: `dac_code`=0, `result`=0, `busy`=0, `done`=0, state IDLE, bit index=WIDTH-1, settle count=0.
- **States:** IDLE and CONV.
- **IDLE:**
  - `busy`=0.
  - `start`=1 → CONV, `busy`=1, `dac_code`=1<<(WIDTH-1), bit=WIDTH-1, cnt=0.
- **CONV:**
  - cnt increments each clock.
  - On the clock where cnt==SETTLE_CYCLES-1 (decision edge), `cmp` is sampled and `dac_code[bit]`=`cmp`.
  - If bit>0: `dac_code[bit-1]`=1, bit decrements, cnt=0.
  - If bit==0: `result` = final code (with bit0=`cmp`), `done`=1, `busy`=0, → IDLE.
  - `dac_code` holds the final code in IDLE.
- `cmp` is ignored except on decision edges.
- `start` is ignored while `busy`=1.
- **Width rules:**
  - bit index is $clog2(WIDTH) bits.
  - cnt is $clog2(SETTLE_CYCLES+1) bits.
  - No arithmetic on the code; bits are only set or cleared.
- **Boundary cases:**
  - `cmp` stuck 1 → result all ones.
  - `cmp` stuck 0 → result 0.
  - SETTLE_CYCLES=1 → one decision per clock.

## Timing
- Latency: `start` captured at edge E0; bits decided at edges E0+S, E0+2S, …, E0+WIDTH·S (S=SETTLE_CYCLES).
- `done` and the new `result` are visible after edge E0+WIDTH·S. Default parameters give 8 clocks.
- `done` is high for exactly one cycle. It deasserts on the next edge regardless of `start`.
- `start` high in the `done` cycle is accepted, since the state is already IDLE. Back-to-back conversions therefore have a WIDTH·S+1 clock period.
- `rst` mid-conversion: at that edge all outputs return to reset values. A pending result is discarded and `done` is not pulsed.
- `rst` and `start` high together: reset wins.

## Structure
- Package `sar_pkg` holds:
  - the state enum (`SAR_IDLE`, `SAR_CONV`);
  - the default `WIDTH`/`SETTLE_CYCLES` constants;
  - a `vref`=1.2 real constant for benches.
- Natural sub-module: `sar_settle_timer`, the cnt counter with load/terminal-count output. The FSM and successive-approximation register stay in `sar_adc4`.
- Bench comparator model: `cmp` = (vin ≥ dac_code·1.2/15), wrapped around `dac4x1`.

## Test plan
- **Reset behaviour:** reset, then `start`, vin=0.5 V.
  - Trial codes are 1000→0100→0110→0111.
  - Result is 0110.
  - `done` arrives 8 clocks after the start edge.
- **Full scale:** vin=1.2 V → result 1111.
- **Zero:** vin=0.0 V → result 0000.
- **Start while busy:** pulse `start` mid-conversion and in the `done` cycle.
  - The mid-conversion start is ignored.
  - The `done`-cycle start begins a new conversion immediately: `busy` high on the next cycle, `dac_code`=1000.
- **Reset mid-conversion:** assert `rst` at the 5th clock of a conversion.
  - All outputs are 0 on the next cycle.
  - No `done` pulse.
  - A following `start` converts vin=0.5 V to 0110.
- **Parameter sweep:** SETTLE_CYCLES=1 and 3.
  - Latency is 4 and 12 clocks respectively.
  - Glitches on `cmp` between decision edges do not alter the result.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and defaults for the 4-bit successive-approximation ADC controller.
package sar_pkg;

  typedef enum logic {
    SAR_IDLE = 1'b0,
    SAR_CONV = 1'b1
  } sar_state_t;

  localparam int  SAR_WIDTH  = 4;
  localparam int  SAR_SETTLE = 2;
  // Full-scale ladder reference, used by comparator models in benches
  localparam real SAR_VREF   = 1.2;

endpackage

// File: rtl/sar_settle_timer.sv
// Settle counter: clears on load, otherwise counts; flags the last settle clock of a bit.
module sar_settle_timer
  import sar_pkg::*;
#(
  parameter int SETTLE_CYCLES = SAR_SETTLE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_tc
);

  localparam int            CW  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] TC  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_load) r_cnt <= '0;
    else               r_cnt <= r_cnt + ONE;
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/sar_adc4.sv
// SAR ADC controller: walks trial codes MSB first into the ladder DAC and
// latches the comparator decision for each bit after its settle window.
module sar_adc4
  import sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SETTLE_CYCLES = SAR_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               BW      = $clog2(WIDTH);
  localparam logic [BW-1:0]    BIT_TOP = BW'(WIDTH - 1);
  localparam logic [BW-1:0]    BIT_ONE = BW'(1);
  localparam logic [WIDTH-1:0] MSB     = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       r_state, w_state_next;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_dac, r_result, w_code_next;
  logic             r_done;
  logic             w_tc, w_load, w_decide, w_last, w_accept;

  sar_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= SAR_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SAR_IDLE: if (start)                        w_state_next = SAR_CONV;
      SAR_CONV: if (w_tc && (r_bit == '0))        w_state_next = SAR_IDLE;
      default:                                    w_state_next = SAR_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == SAR_IDLE) && start;
    w_decide = (r_state == SAR_CONV) && w_tc;
    w_last   = w_decide && (r_bit == '0);
    // Counter restarts every bit and is held cleared while idle
    w_load   = (r_state != SAR_CONV) || w_tc;
    w_code_next        = r_dac;
    w_code_next[r_bit] = cmp;
    if (r_bit != '0) w_code_next[r_bit - BIT_ONE] = 1'b1;
  end

  // Successive-approximation register and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dac    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_bit    <= BIT_TOP;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dac <= MSB;
        r_bit <= BIT_TOP;
      end else if (w_decide) begin
        r_dac <= w_code_next;
        if (w_last) begin
          r_result <= w_code_next;
          r_done   <= 1'b1;
        end else begin
          r_bit <= r_bit - BIT_ONE;
        end
      end
    end
  end

  assign dac_code = r_dac;
  assign result   = r_result;
  assign done     = r_done;
  assign busy     = (r_state == SAR_CONV);

endmodule

// File: tb/tb_sar_adc4.sv
// Bench for sar_adc4: three instances (settle 2, 1, 3) each driven by a ladder/comparator model.
module tb_sar_adc4;
  import sar_pkg::*;

  localparam int SV [3] = '{2, 1, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [3];
  logic       cmp_v   [3];
  logic       inv     [3];
  real        vin_v   [3];
  logic [3:0] dac_o   [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic [3:0] result_o[3];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  sar_adc4 #(.WIDTH(4), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .cmp(cmp_v[0]),
    .dac_code(dac_o[0]), .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]));
  sar_adc4 #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .cmp(cmp_v[1]),
    .dac_code(dac_o[1]), .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]));
  sar_adc4 #(.WIDTH(4), .SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .cmp(cmp_v[2]),
    .dac_code(dac_o[2]), .busy(busy_o[2]), .done(done_o[2]), .result(result_o[2]));

  // Ladder DAC plus comparator; inv forces a wrong answer to emulate glitches
  for (genvar g = 0; g < 3; g++) begin : g_cmp
    assign cmp_v[g] = ((vin_v[g] + 1.0e-6) >= (real'(dac_o[g]) * SAR_VREF / 15.0)) ^ inv[g];
  end

  function automatic logic [3:0] ref_code(input real v);
    logic [3:0] code = 4'd0;
    logic [3:0] trial;
    for (int b = 3; b >= 0; b--) begin
      trial = code | (4'd1 << b);
      if ((v + 1.0e-6) >= (real'(trial) * SAR_VREF / 15.0)) code = trial;
    end
    return code;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for done, counting edges already elapsed since the start edge in lat
  task automatic wait_done(input int idx, input bit glitch, inout int lat);
    while (!done_o[idx] && lat < 64) begin
      inv[idx] = glitch && (((lat + 1) % SV[idx]) != 0);
      tick();
      lat++;
    end
    inv[idx] = 1'b0;
    chk("done_seen", done_o[idx], 1);
    chk("busy_in_done", busy_o[idx], 0);
    if (sb.size() > 0) chk("result_sb", result_o[idx], sb.pop_front());
    else chk("sb_nonempty", 0, 1);
  endtask

  task automatic start_conv(input int idx, input real v);
    vin_v[idx]   = v;
    start_v[idx] = 1'b1;
    sb.push_back(ref_code(v));
    tick();
    start_v[idx] = 1'b0;
  endtask

  initial begin
    int lat;
    int nd;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; inv[i] = 1'b0; vin_v[i] = 0.0;
    end
    tick(); tick();
    chk("rst_state_dac", dac_o[0], 0);
    chk("rst_state_busy", busy_o[0], 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_dac", dac_o[i], 0);
      chk("reset_result", result_o[i], 0);
      chk("reset_busy", busy_o[i], 0);
      chk("reset_done", done_o[i], 0);
    end

    // 0.5 V with trial-code trace
    start_conv(0, 0.5);
    chk("t1_busy", busy_o[0], 1);
    chk("t1_trial0", dac_o[0], 4'b1000);
    lat = 0;
    while (!done_o[0] && lat < 64) begin
      tick();
      lat++;
      if (lat == 2) chk("t1_trial1", dac_o[0], 4'b0100);
      if (lat == 4) chk("t1_trial2", dac_o[0], 4'b0110);
      if (lat == 6) chk("t1_trial3", dac_o[0], 4'b0111);
    end
    chk("t1_latency", lat, 8);
    chk("t1_result", result_o[0], 4'b0110);
    chk("t1_result_sb", result_o[0], sb.pop_front());
    tick();
    chk("t1_done_pulse", done_o[0], 0);
    chk("t1_dac_hold", dac_o[0], 4'b0110);

    // Zero scale
    start_conv(0, 0.0);
    lat = 0;
    wait_done(0, 1'b0, lat);
    chk("zero_result", result_o[0], 4'b0000);
    tick();

    // Start while busy, then start in the done cycle
    start_conv(0, 0.5);
    tick(); tick();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    lat = 3;
    wait_done(0, 1'b0, lat);
    chk("bsy_latency", lat, 8);
    chk("bsy_result", result_o[0], 4'b0110);
    start_conv(0, 1.2);
    chk("b2b_busy", busy_o[0], 1);
    chk("b2b_dac", dac_o[0], 4'b1000);
    chk("b2b_done_low", done_o[0], 0);
    lat = 0;
    wait_done(0, 1'b0, lat);
    chk("full_latency", lat, 8);
    chk("full_result", result_o[0], 4'b1111);
    tick();

    // Reset mid-conversion
    start_conv(0, 0.5);
    void'(sb.pop_front());
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_dac", dac_o[0], 0);
    chk("mrst_busy", busy_o[0], 0);
    chk("mrst_done", done_o[0], 0);
    chk("mrst_result", result_o[0], 0);
    nd = 0;
    repeat (12) begin
      tick();
      if (done_o[0]) nd++;
    end
    chk("mrst_no_done", nd, 0);
    chk("mrst_idle", busy_o[0], 0);

    // Reset wins over start
    rst = 1'b1; start_v[0] = 1'b1; vin_v[0] = 0.5;
    tick();
    rst = 1'b0; start_v[0] = 1'b0;
    chk("rst_start_busy", busy_o[0], 0);
    chk("rst_start_dac", dac_o[0], 0);

    start_conv(0, 0.5);
    lat = 0;
    wait_done(0, 1'b0, lat);
    chk("post_rst_result", result_o[0], 4'b0110);
    tick();

    // Settle sweep: S=1 and S=3 (with glitches between decisions)
    start_conv(1, 0.5);
    lat = 0;
    wait_done(1, 1'b0, lat);
    chk("s1_latency", lat, 4);
    chk("s1_result", result_o[1], 4'b0110);
    tick();
    start_conv(1, 1.2);
    lat = 0;
    wait_done(1, 1'b0, lat);
    chk("s1_full", result_o[1], 4'b1111);
    tick();

    start_conv(2, 0.5);
    lat = 0;
    wait_done(2, 1'b1, lat);
    chk("s3_latency", lat, 12);
    chk("s3_result", result_o[2], 4'b0110);
    tick();
    chk("s3_done_pulse", done_o[2], 0);
    start_conv(2, 0.9);
    lat = 0;
    wait_done(2, 1'b1, lat);
    chk("s3_glitch_result", result_o[2], 4'b1011);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
